// File: rtl/stat_reg_pkg.sv
// Shared constants for the stat_reg_16 status/counter bank: word addresses,
// counter width, identification word and clear-register bit positions.
package stat_reg_pkg;

  localparam int CNT_W = 32;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  localparam logic [15:0] ID_WORD = 16'h5A16;

  localparam logic [4:0] ADDR_SAMPLE_LO = 5'd0;
  localparam logic [4:0] ADDR_SPKDET_LO = 5'd2;
  localparam logic [4:0] ADDR_SPKCLF_LO = 5'd4;
  localparam logic [4:0] ADDR_OVF_LO    = 5'd6;
  localparam logic [4:0] ADDR_FLAGS     = 5'd16;
  localparam logic [4:0] ADDR_CLEAR     = 5'd17;
  localparam logic [4:0] ADDR_ID        = 5'd31;

  localparam int CLR_FLAGS_BIT  = 8;
  localparam int CLR_SHADOW_BIT = 9;

endpackage

// File: rtl/stat_reg_16_evt_counter.sv
// Single 32-bit event counter with synchronous clear.
// Build option STAT_SATURATE_EN: hold at all-ones instead of wrapping.
// wrap_o pulses in the cycle whose event wraps the counter (or, when
// saturating, reaches all-ones or is dropped because it is already there).
module evt_counter
  import stat_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o,
  output logic             wrap_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             wrap_d;

  // Next count: clear beats a same-cycle event.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
`ifdef STAT_SATURATE_EN
      if (count_q == CNT_MAX) begin
        wrap_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
        wrap_d  = (count_q == (CNT_MAX - CNT_W'(1)));
      end
`else
      count_d = count_q + CNT_W'(1);
      wrap_d  = (count_q == CNT_MAX);
`endif
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_d;

endmodule

// File: rtl/stat_reg_16.sv
// stat_reg_16: FPGA-to-host status/counter bank on a 16-bit, 5-bit-address
// control-register bus. Four 32-bit event counters read as low/high word
// pairs through a shared shadow register, sticky flags with an interrupt,
// and a write-one-to-clear register. Build option: STAT_SATURATE_EN.
module stat_reg_16
  import stat_reg_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] din,
  input  logic        we,
  input  logic        re,
  input  logic [4:0]  addr,
  output logic [15:0] dout,
  input  logic        evt_sample,
  input  logic        evt_spkdet,
  input  logic        evt_spkclf,
  input  logic        evt_ovf,
  output logic        stat_irq
);

  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       wrap;
  logic [3:0]       clr;
  logic             clr_wr;

  logic [15:0] dout_q, dout_d;
  logic [15:0] shadow_q, shadow_d;
  logic [4:0]  flags_q, flags_d;
  logic        irq_q, irq_d;

  logic [15:0] rd_data;
  logic        shadow_ld;

  logic unused_din;
  assign unused_din = ^{din[15:10], din[7:4]};

  assign clr_wr = we && (addr == ADDR_CLEAR);
  assign clr    = clr_wr ? din[3:0] : 4'b0000;

  evt_counter u_cnt_sample (
    .clk(clk), .rst(rst), .inc_i(evt_sample), .clr_i(clr[0]),
    .count_o(cnt[0]), .wrap_o(wrap[0])
  );

  evt_counter u_cnt_spkdet (
    .clk(clk), .rst(rst), .inc_i(evt_spkdet), .clr_i(clr[1]),
    .count_o(cnt[1]), .wrap_o(wrap[1])
  );

  evt_counter u_cnt_spkclf (
    .clk(clk), .rst(rst), .inc_i(evt_spkclf), .clr_i(clr[2]),
    .count_o(cnt[2]), .wrap_o(wrap[2])
  );

  evt_counter u_cnt_ovf (
    .clk(clk), .rst(rst), .inc_i(evt_ovf), .clr_i(clr[3]),
    .count_o(cnt[3]), .wrap_o(wrap[3])
  );

  // Read mux on pre-edge state; low-word reads also request a shadow load.
  always_comb begin
    rd_data   = 16'h0000;
    shadow_ld = 1'b0;
    if (addr[4:3] == 2'b00) begin
      if (!addr[0]) begin
        rd_data   = cnt[addr[2:1]][15:0];
        shadow_ld = 1'b1;
      end else begin
        rd_data = shadow_q;
      end
    end else if (addr == ADDR_FLAGS) begin
      rd_data = {11'b0, flags_q};
    end else if (addr == ADDR_ID) begin
      rd_data = ID_WORD;
    end
  end

  // Next state for read data, shadow, flags and interrupt; clears win.
  always_comb begin
    dout_d   = re ? rd_data : dout_q;
    shadow_d = shadow_q;
    if (clr_wr && din[CLR_SHADOW_BIT])
      shadow_d = 16'h0000;
    else if (re && shadow_ld)
      shadow_d = cnt[addr[2:1]][31:16];
    if (clr_wr && din[CLR_FLAGS_BIT])
      flags_d = 5'b0;
    else
      flags_d = flags_q | {evt_ovf, wrap};
    irq_d = |flags_q;
  end

  // Control/status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q   <= 16'h0000;
      shadow_q <= 16'h0000;
      flags_q  <= 5'b0;
      irq_q    <= 1'b0;
    end else begin
      dout_q   <= dout_d;
      shadow_q <= shadow_d;
      flags_q  <= flags_d;
      irq_q    <= irq_d;
    end
  end

  assign dout     = dout_q;
  assign stat_irq = irq_q;

endmodule

// File: tb/tb_stat_reg_16.sv
// Directed self-checking bench for stat_reg_16 (wrap or STAT_SATURATE_EN build).
module tb_stat_reg_16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = 16'h0000;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [15:0] dout;
  logic        evt_sample = 1'b0;
  logic        evt_spkdet = 1'b0;
  logic        evt_spkclf = 1'b0;
  logic        evt_ovf = 1'b0;
  logic        stat_irq;

  int n_checks = 0;
  int n_fail   = 0;

  stat_reg_16 dut (
    .clk(clk), .rst(rst), .din(din), .we(we), .re(re), .addr(addr),
    .dout(dout), .evt_sample(evt_sample), .evt_spkdet(evt_spkdet),
    .evt_spkclf(evt_spkclf), .evt_ovf(evt_ovf), .stat_irq(stat_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [4:0] a, output logic [15:0] d);
    addr = a;
    re   = 1'b1;
    step();
    re   = 1'b0;
    d    = dout;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    addr = a;
    din  = d;
    we   = 1'b1;
    step();
    we   = 1'b0;
    din  = 16'h0000;
  endtask

  logic [15:0] r;
  logic [15:0] exp_wrap;

  initial begin
`ifdef STAT_SATURATE_EN
    exp_wrap = 16'hFFFF;
`else
    exp_wrap = 16'h0000;
`endif

    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_dout", dout, 16'h0000);
    chk("rst_irq", {15'b0, stat_irq}, 16'h0000);
    for (int a = 0; a < 8; a++) begin
      rd(5'(a), r);
      chk($sformatf("rst_cnt%0d", a), r, 16'h0000);
    end
    rd(5'd16, r); chk("rst_flags", r, 16'h0000);
    rd(5'd31, r); chk("id_word", r, 16'h5A16);

    // 70000 spike detections -> 0x00011170
    evt_spkdet = 1'b1;
    repeat (70000) step();
    evt_spkdet = 1'b0;
    rd(5'd2, r); chk("spkdet_lo", r, 16'h1170);
    rd(5'd3, r); chk("spkdet_hi", r, 16'h0001);
    rd(5'd16, r); chk("flags_after_spkdet", r, 16'h0000);

    // Coherent snapshot across a carry into the high word
    force dut.u_cnt_sample.count_q = 32'h0001FFFF;
    step();
    release dut.u_cnt_sample.count_q;
    evt_sample = 1'b1;
    rd(5'd0, r); chk("snap_lo", r, 16'hFFFF);
    repeat (3) step();
    evt_sample = 1'b0;
    rd(5'd1, r); chk("snap_hi_latched", r, 16'h0001);
    rd(5'd0, r); chk("live_lo", r, 16'h0003);
    rd(5'd1, r); chk("live_hi", r, 16'h0002);
    rd(5'd3, r); chk("shared_shadow", r, 16'h0002);

    // Wrap / saturate at all-ones
    force dut.u_cnt_sample.count_q = 32'hFFFFFFFF;
    step();
    release dut.u_cnt_sample.count_q;
    evt_sample = 1'b1;
    step();
    evt_sample = 1'b0;
    chk("irq_not_yet", {15'b0, stat_irq}, 16'h0000);
    step();
    chk("irq_set", {15'b0, stat_irq}, 16'h0001);
    rd(5'd16, r); chk("flag_bit0", r, 16'h0001);
    rd(5'd0, r); chk("wrap_lo", r, exp_wrap);
    rd(5'd1, r); chk("wrap_hi", r, exp_wrap);

    // Clear spkdet + flags in the same cycle as a spkdet event
    addr = 5'd17;
    din = 16'h0102;
    we = 1'b1;
    evt_spkdet = 1'b1;
    step();
    we = 1'b0;
    din = 16'h0000;
    evt_spkdet = 1'b0;
    rd(5'd2, r); chk("clr_spkdet_lo", r, 16'h0000);
    rd(5'd3, r); chk("clr_spkdet_hi", r, 16'h0000);
    rd(5'd16, r); chk("clr_flags", r, 16'h0000);
    rd(5'd0, r); chk("sample_kept_lo", r, exp_wrap);
    rd(5'd1, r); chk("sample_kept_hi", r, exp_wrap);
    chk("irq_cleared", {15'b0, stat_irq}, 16'h0000);

    // Overflow event: counter and flag bit 4
    evt_ovf = 1'b1;
    step();
    evt_ovf = 1'b0;
    rd(5'd6, r); chk("ovf_lo", r, 16'h0001);
    rd(5'd16, r); chk("flag_bit4", r, 16'h0010);
    rd(5'd17, r); chk("clear_reads_0", r, 16'h0000);
    rd(5'd10, r); chk("unmapped_reads_0", r, 16'h0000);
    wr(5'd10, 16'hFFFF);
    rd(5'd6, r); chk("unmapped_wr_ovf", r, 16'h0001);
    rd(5'd16, r); chk("unmapped_wr_flags", r, 16'h0010);
    chk("irq_ovf", {15'b0, stat_irq}, 16'h0001);

    // Reset while a read is pending
    force dut.u_cnt_ovf.count_q = 32'h0000BEEF;
    step();
    release dut.u_cnt_ovf.count_q;
    rd(5'd6, r); chk("beef", r, 16'hBEEF);
    addr = 5'd6;
    re = 1'b1;
    rst = 1'b1;
    step();
    chk("rst_mid_read_dout", dout, 16'h0000);
    re = 1'b0;
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      rd(5'(a), r);
      chk($sformatf("rst2_cnt%0d", a), r, 16'h0000);
    end
    rd(5'd16, r); chk("rst2_flags", r, 16'h0000);
    chk("rst2_irq", {15'b0, stat_irq}, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stat_reg_16.md
Name: stat_reg_16

Overview:
- FPGA-to-host status/counter bank on the 16-bit addressable Xillybus control-register interface (5-bit address, 16-bit data).
- Counts pipeline events (samples, spike detections, spike classifications, FIFO overflows) in 32-bit counters.
- Host reads counters as 16-bit word pairs with a coherent low/high snapshot, and clears them via write-one-to-clear.
- Complements the host-to-FPGA command register bank on the same bus.

Parameters:
- CNT_W, 32, counter width; fixed at 32, as every counter occupies exactly two 16-bit words.
- ID_WORD, 16'h5A16, constant returned at address 31.

Ports:
- clk  input  1  bus_clk domain; all logic is on this edge.
- rst  input  1  synchronous, active-high reset.
- din  input  16  host write data.
- we  input  1  host write strobe, one cycle per word.
- re  input  1  host read strobe, one cycle per word.
- addr  input  5  word address.
- dout  output  16  registered read data.
- evt_sample  input  1  one sample frame accepted this cycle.
- evt_spkdet  input  1  one spike detected this cycle.
- evt_spkclf  input  1  one spike classified this cycle.
- evt_ovf  input  1  downstream FIFO overflow this cycle.
- stat_irq  output  1  high while any sticky flag is set.

Behaviour:
Address map (word addresses):
- 0/1: sample count, low/high.
- 2/3: spike-detect count, low/high.
- 4/5: spike-classify count, low/high.
- 6/7: overflow count, low/high.
- 16: sticky flags; bit k set when counter k wraps (or saturates); bit 4 set on any evt_ovf.
- 17: clear register; write-only, reads return 0.
- 31: ID_WORD.
- All others: read 0; writes ignored.

Reset:
- All counters, the shadow register and the flags become 0.
- dout = 0, stat_irq = 0.

Read:
- dout updates on the clk edge after re is sampled high, so latency is 1 cycle.
- When re is low, dout holds its previous value.
- Reading an even (low) address returns bits[15:0] and, in the same edge, loads the 16-bit shadow with bits[31:16] of the same pre-increment value.
- Reading the odd (high) address returns the shadow, not the live counter.
- Reading high without a preceding low read returns the last latched shadow.
- A single shadow is shared by all counters; the last low read wins.

Increment:
- Each counter adds 1 per cycle while its evt_* input is high.
- Counters wrap from 0xFFFFFFFF to 0 and set the matching sticky flag.
- A read in the same cycle as an increment returns the pre-increment value.

Clear (write to address 17):
- din[k] = 1 zeroes counter k, for k = 0..3.
- din[8] = 1 clears all sticky flags.
- din[9] = 1 zeroes the shadow.
- Clear has priority over a same-cycle event: the counter becomes 0 and the event is dropped.
- Clearing flags has priority over a same-cycle flag set.
- Writes to other addresses have no effect.

Simultaneous access:
- When we and re are both high in one cycle, the read is evaluated on pre-write state.

Interrupt:
- stat_irq is the registered OR of the flags, so it asserts 1 cycle after the flag sets.

Reset mid-read:
- Reset overrides; dout = 0 on the next edge.

Optional Feature:
- Macro: STAT_SATURATE_EN.
- Defined: counters hold at 0xFFFFFFFF instead of wrapping. The sticky flag sets on reaching saturation. Further events are ignored until cleared.
- Undefined: counters wrap modulo 2^32, as described above.

Decomposition:
- Package stat_reg_pkg holds:
  - address constants: ADDR_SAMPLE_LO, ADDR_SPKDET_LO, ADDR_SPKCLF_LO, ADDR_OVF_LO, ADDR_FLAGS, ADDR_CLEAR, ADDR_ID;
  - ID_WORD and CNT_W;
  - clear-bit indices CLR_FLAGS_BIT = 8 and CLR_SHADOW_BIT = 9.
- Sub-module evt_counter: one 32-bit counter with inputs inc and clr, outputs count and a one-cycle wrap/saturate pulse. It contains the STAT_SATURATE_EN ifdef. Instantiated 4 times.

Test Plan:
- Reset, then read addresses 0..7, 16 and 31: returns 0 for all counters and flags, 16'h5A16 at 31, stat_irq = 0.
- Hold evt_spkdet high for 70000 cycles, read address 2 then 3: returns 16'h1170, then 16'h0001.
- Read address 0 while evt_sample is high on the same and later cycles, then read address 1: the high word matches the value latched at the low read, not the live counter.
- Force the sample counter to 0xFFFFFFFF, then pulse evt_sample once:
  - without the macro: count = 0, flag bit0 = 1, stat_irq = 1 one cycle later;
  - with STAT_SATURATE_EN: count = 0xFFFFFFFF, flag bit0 = 1.
- Write 16'h0102 to address 17 in the same cycle as evt_spkdet: the spike-detect count reads 0, flags read 0, and the sample count is unchanged.
- Assert rst while re is pending with dout = 16'hBEEF: dout = 0 and all counters = 0 on the next edge.
